factorial_seq_ctrl: RTL and testbench

//  Parametrised sequential controller for factorial / falling-factorial products.

---
 rtl/factorial_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_factorial_seq_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/factorial_seq_ctrl.sv
// rtl/factorial_seq_ctrl.sv - sequential falling-factorial controller driving an external iterative multiplier
module factorial_seq_ctrl #(
    parameter int WIDTH     = 64,
    parameter int RES_WIDTH = 2 * WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     operand,
    input  logic [WIDTH-1:0]     stop,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [RES_WIDTH-1:0] result,
    output logic                 mul_start,
    output logic                 mul_clear,
    output logic [WIDTH-1:0]     mul_multiplier,
    output logic [WIDTH-1:0]     mul_multiplicand,
    input  logic                 mul_done,
    input  logic [RES_WIDTH-1:0] mul_result
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_CLR, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     k_q, k_d;
    logic [RES_WIDTH-1:0] product_q, product_d;
    logic [RES_WIDTH-1:0] result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 overflow_q, overflow_d;
    logic                 mul_start_q, mul_start_d;
    logic                 mul_clear_q, mul_clear_d;
    logic [WIDTH-1:0]     mul_multiplier_q, mul_multiplier_d;
    logic [WIDTH-1:0]     mul_multiplicand_q, mul_multiplicand_d;
    logic [WIDTH-1:0]     n_dec;
    logic [WIDTH-1:0]     cnt_dec;

    assign n_dec   = operand - 1'b1;
    assign cnt_dec = cnt_q - 1'b1;

    // Registered outputs are computed from the next state so they line up with state_q.
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        k_d                = k_q;
        product_d          = product_q;
        result_d           = result_q;
        busy_d             = busy_q;
        done_d             = 1'b0;
        overflow_d         = overflow_q;
        mul_start_d        = 1'b0;
        mul_clear_d        = 1'b0;
        mul_multiplier_d   = mul_multiplier_q;
        mul_multiplicand_d = mul_multiplicand_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d        = stop;
                    busy_d     = 1'b1;
                    overflow_d = 1'b0;
                    if (operand <= stop) begin
                        product_d = RES_WIDTH'(1);
                        state_d   = S_DONE;
                    end else if (n_dec == stop) begin
                        product_d = RES_WIDTH'(operand);
                        state_d   = S_DONE;
                    end else begin
                        product_d          = RES_WIDTH'(operand);
                        cnt_d              = n_dec;
                        state_d            = S_MUL;
                        mul_start_d        = 1'b1;
                        mul_multiplier_d   = operand;
                        mul_multiplicand_d = n_dec;
                    end
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    product_d   = mul_result;
                    mul_clear_d = 1'b1;
                    state_d     = S_CLR;
                end else begin
                    mul_start_d = 1'b1;
                end
            end
            S_CLR: begin
                cnt_d = cnt_dec;
                if (cnt_dec == k_q) begin
                    state_d = S_DONE;
                end else if (product_q[RES_WIDTH-1:WIDTH] != '0) begin
                    // Next multiplier operand would be truncated; stop with the partial product.
                    overflow_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    state_d            = S_MUL;
                    mul_start_d        = 1'b1;
                    mul_multiplier_d   = product_q[WIDTH-1:0];
                    mul_multiplicand_d = cnt_dec;
                end
            end
            S_DONE: begin
                result_d = product_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= S_IDLE;
            cnt_q              <= '0;
            k_q                <= '0;
            product_q          <= RES_WIDTH'(1);
            result_q           <= RES_WIDTH'(1);
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            overflow_q         <= 1'b0;
            mul_start_q        <= 1'b0;
            mul_clear_q        <= 1'b1;
            mul_multiplier_q   <= '0;
            mul_multiplicand_q <= '0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            k_q                <= k_d;
            product_q          <= product_d;
            result_q           <= result_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            overflow_q         <= overflow_d;
            mul_start_q        <= mul_start_d;
            mul_clear_q        <= mul_clear_d;
            mul_multiplier_q   <= mul_multiplier_d;
            mul_multiplicand_q <= mul_multiplicand_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign overflow         = overflow_q;
    assign result           = result_q;
    assign mul_start        = mul_start_q;
    assign mul_clear        = mul_clear_q;
    assign mul_multiplier   = mul_multiplier_q;
    assign mul_multiplicand = mul_multiplicand_q;

endmodule

// File: tb/tb_factorial_seq_ctrl.sv
// tb/tb_factorial_seq_ctrl.sv - table-driven bench for factorial_seq_ctrl with 3-cycle multiplier stubs
module tb_factorial_seq_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A: WIDTH=64
    logic         start_a = 1'b0;
    logic [63:0]  operand_a = '0, stop_a = '0;
    logic         busy_a, done_a, overflow_a, mul_start_a, mul_clear_a;
    logic [127:0] result_a;
    logic [63:0]  mul_multiplier_a, mul_multiplicand_a;
    logic         mul_done_a = 1'b0;
    logic [127:0] mul_result_a = '0;

    // Instance B: WIDTH=8
    logic         start_b = 1'b0;
    logic [7:0]   operand_b = '0, stop_b = '0;
    logic         busy_b, done_b, overflow_b, mul_start_b, mul_clear_b;
    logic [15:0]  result_b;
    logic [7:0]   mul_multiplier_b, mul_multiplicand_b;
    logic         mul_done_b = 1'b0;
    logic [15:0]  mul_result_b = '0;

    factorial_seq_ctrl #(.WIDTH(64)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .operand(operand_a), .stop(stop_a),
        .busy(busy_a), .done(done_a), .overflow(overflow_a), .result(result_a),
        .mul_start(mul_start_a), .mul_clear(mul_clear_a),
        .mul_multiplier(mul_multiplier_a), .mul_multiplicand(mul_multiplicand_a),
        .mul_done(mul_done_a), .mul_result(mul_result_a)
    );

    factorial_seq_ctrl #(.WIDTH(8)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .operand(operand_b), .stop(stop_b),
        .busy(busy_b), .done(done_b), .overflow(overflow_b), .result(result_b),
        .mul_start(mul_start_b), .mul_clear(mul_clear_b),
        .mul_multiplier(mul_multiplier_b), .mul_multiplicand(mul_multiplicand_b),
        .mul_done(mul_done_b), .mul_result(mul_result_b)
    );

    int sc_a = 0, sc_b = 0;
    always @(posedge clk) begin
        if (reset || mul_clear_a || !mul_start_a) begin
            sc_a <= 0; mul_done_a <= 1'b0;
        end else if (mul_done_a) begin
            mul_done_a <= 1'b0;
        end else if (sc_a == 2) begin
            mul_done_a   <= 1'b1;
            mul_result_a <= {64'b0, mul_multiplier_a} * {64'b0, mul_multiplicand_a};
        end else begin
            sc_a <= sc_a + 1;
        end
    end
    always @(posedge clk) begin
        if (reset || mul_clear_b || !mul_start_b) begin
            sc_b <= 0; mul_done_b <= 1'b0;
        end else if (mul_done_b) begin
            mul_done_b <= 1'b0;
        end else if (sc_b == 2) begin
            mul_done_b   <= 1'b1;
            mul_result_b <= {8'b0, mul_multiplier_b} * {8'b0, mul_multiplicand_b};
        end else begin
            sc_b <= sc_b + 1;
        end
    end

    int done_cnt_a = 0, done_cnt_b = 0, mul_cnt_a = 0, mul_cnt_b = 0;
    logic [63:0] mcand_log [0:255];
    always @(posedge clk) begin
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        if (mul_done_b) mul_cnt_b <= mul_cnt_b + 1;
        if (mul_done_a) begin
            mcand_log[mul_cnt_a[7:0]] <= mul_multiplicand_a;
            mul_cnt_a <= mul_cnt_a + 1;
        end
    end

    int tests = 0, fails = 0;
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input bit w8, input logic [63:0] n, input logic [63:0] k,
                       output logic [127:0] res, output logic ovf, output int nmul,
                       output int ndone, output bit timed_out);
        int m0, d0;
        m0 = w8 ? mul_cnt_b : mul_cnt_a;
        d0 = w8 ? done_cnt_b : done_cnt_a;
        @(negedge clk);
        if (w8) begin start_b = 1'b1; operand_b = n[7:0]; stop_b = k[7:0]; end
        else begin start_a = 1'b1; operand_a = n; stop_a = k; end
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (w8 ? done_b : done_a) begin timed_out = 1'b0; break; end
            @(negedge clk);
        end
        res = w8 ? {112'b0, result_b} : result_a;
        ovf = w8 ? overflow_b : overflow_a;
        repeat (3) @(negedge clk);
        nmul  = (w8 ? mul_cnt_b : mul_cnt_a) - m0;
        ndone = (w8 ? done_cnt_b : done_cnt_a) - d0;
    endtask

    typedef struct {
        bit           w8;
        logic [63:0]  n;
        logic [63:0]  k;
        logic [127:0] res;
        logic         ovf;
        int           nmul;
    } vec_t;
    vec_t vecs [12];

    initial begin
        logic [127:0] res;
        logic         ovf;
        int           nmul, ndone, m0;
        bit           to;

        vecs[0]  = '{1'b0, 64'd5,  64'd0, 128'd120, 1'b0, 4};
        vecs[1]  = '{1'b0, 64'd0,  64'd0, 128'd1,   1'b0, 0};
        vecs[2]  = '{1'b0, 64'd1,  64'd0, 128'd1,   1'b0, 0};
        vecs[3]  = '{1'b0, 64'd7,  64'd4, 128'd210, 1'b0, 2};
        vecs[4]  = '{1'b0, 64'd3,  64'd5, 128'd1,   1'b0, 0};
        vecs[5]  = '{1'b0, 64'd6,  64'd5, 128'd6,   1'b0, 0};
        vecs[6]  = '{1'b0, 64'd10, 64'd7, 128'd720, 1'b0, 2};
        vecs[7]  = '{1'b0, 64'd20, 64'd0, 128'd2432902008176640000, 1'b0, 19};
        vecs[8]  = '{1'b0, 64'd21, 64'd0, 128'd25545471085854720000, 1'b1, 18};
        vecs[9]  = '{1'b1, 64'd6,  64'd0, 128'd360, 1'b1, 3};
        vecs[10] = '{1'b1, 64'd6,  64'd2, 128'd360, 1'b0, 3};
        vecs[11] = '{1'b1, 64'd5,  64'd0, 128'd120, 1'b0, 4};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_ovf", overflow_a, 0);
        check("rst_result", result_a, 1);
        check("rst_mul_start", mul_start_a, 0);
        check("rst_mul_clear", mul_clear_a, 1);
        check("rst_mul_mplier", mul_multiplier_a, 0);
        check("rst_mul_mcand", mul_multiplicand_a, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_mul_clear", mul_clear_a, 0);

        // Trivial-run latency: done exactly two cycles after start
        start_a = 1'b1; operand_a = 64'd0; stop_a = 64'd0;
        @(negedge clk);
        start_a = 1'b0;
        check("triv_busy_c1", busy_a, 1);
        check("triv_done_c1", done_a, 0);
        check("triv_mul_start_c1", mul_start_a, 0);
        @(negedge clk);
        check("triv_done_c2", done_a, 1);
        check("triv_busy_c2", busy_a, 0);
        check("triv_result", result_a, 1);
        @(negedge clk);
        check("triv_done_c3", done_a, 0);

        for (int i = 0; i < 12; i++) begin
            run(vecs[i].w8, vecs[i].n, vecs[i].k, res, ovf, nmul, ndone, to);
            check($sformatf("v%0d_timeout", i), to, 0);
            check($sformatf("v%0d_result", i), res, vecs[i].res);
            check($sformatf("v%0d_overflow", i), ovf, vecs[i].ovf);
            check($sformatf("v%0d_nmul", i), nmul, vecs[i].nmul);
            check($sformatf("v%0d_ndone", i), ndone, 1);
        end

        // Multiplicand sequence for n=7, k=4
        m0 = mul_cnt_a;
        run(1'b0, 64'd7, 64'd4, res, ovf, nmul, ndone, to);
        check("mcand_first", mcand_log[m0[7:0]], 6);
        check("mcand_second", mcand_log[m0[7:0] + 8'd1], 5);

        // Start re-pulsed during MUL is ignored and not queued
        @(negedge clk);
        start_a = 1'b1; operand_a = 64'd7; stop_a = 64'd4;
        @(negedge clk);
        start_a = 1'b0;
        to = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (mul_start_a) begin to = 1'b0; break; end
            @(negedge clk);
        end
        check("repulse_reach_mul", to, 0);
        start_a = 1'b1; operand_a = 64'd5; stop_a = 64'd0;
        @(negedge clk);
        start_a = 1'b0;
        to = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (done_a) begin to = 1'b0; break; end
            @(negedge clk);
        end
        check("repulse_timeout", to, 0);
        check("repulse_result", result_a, 210);
        repeat (4) @(negedge clk);
        check("repulse_not_queued", busy_a, 0);

        // Reset asserted while in MUL
        start_a = 1'b1; operand_a = 64'd5; stop_a = 64'd0;
        @(negedge clk);
        start_a = 1'b0;
        to = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (mul_start_a) begin to = 1'b0; break; end
            @(negedge clk);
        end
        check("midrst_reach_mul", to, 0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_mul_start", mul_start_a, 0);
        check("midrst_mul_clear", mul_clear_a, 1);
        check("midrst_busy", busy_a, 0);
        check("midrst_result", result_a, 1);
        check("midrst_done", done_a, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_idle_busy", busy_a, 0);
        check("midrst_idle_mul_clear", mul_clear_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
